// File: rtl/pipe_reg.sv
// Fixed-latency pipeline register: STAGES back-to-back WIDTH-bit flops between in and out.
// All stages clear to RESET_VALUE asynchronously while rst is low.
module pipe_reg #(
   parameter int                 WIDTH       = 32,
   parameter int                 STAGES      = 1,
   parameter logic [0:WIDTH-1]   RESET_VALUE = '0
) (
   output logic [0:WIDTH-1] out,
   input  logic [0:WIDTH-1] in,
   input  logic             clk,
   input  logic             rst
);

   generate
      if (STAGES < 1) begin : g_bad_stages
         $error("pipe_reg: STAGES must be >= 1");
      end
   endgenerate

   logic [0:WIDTH-1] r_stage [STAGES];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_stage[k] <= RESET_VALUE;
         end
      end else begin
         r_stage[0] <= in;
         for (int k = 1; k < STAGES; k++) begin
            r_stage[k] <= r_stage[k-1];
         end
      end
   end

   // out comes straight from the last flop so there is no in-to-out combinational path
   assign out = r_stage[STAGES-1];

endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg: three instances (16b/1 stage, 8b/3 stages, 16b/1 stage
// with non-zero reset value) checked against a queue-based history model every cycle.
module tb_pipe_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [0:15] in_a = '0, out_a;
   logic [0:7]  in_b = '0, out_b;
   logic [0:15] in_c = '0, out_c;

   int n_tests = 0;
   int n_fail  = 0;

   pipe_reg #(16) u_a (.out(out_a), .in(in_a), .clk(clk), .rst(rst));
   pipe_reg #(8, 3) u_b (.out(out_b), .in(in_b), .clk(clk), .rst(rst));
   pipe_reg #(.WIDTH(16), .STAGES(1), .RESET_VALUE(16'hA5A5)) u_c
      (.out(out_c), .in(in_c), .clk(clk), .rst(rst));

   // Model: history of values captured since the last reset; out is the value
   // captured STAGES edges back, or the reset value if fewer edges have occurred.
   logic [0:15] q_a [$];
   logic [0:7]  q_b [$];
   logic [0:15] q_c [$];

   always @(negedge rst) begin
      q_a.delete();
      q_b.delete();
      q_c.delete();
   end

   always @(posedge clk) begin
      if (rst) begin
         q_a.push_back(in_a);
         q_b.push_back(in_b);
         q_c.push_back(in_c);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [0:15] e_a, e_c;
      logic [0:7]  e_b;
      e_a = (q_a.size() >= 1) ? q_a[q_a.size()-1] : 16'h0000;
      e_b = (q_b.size() >= 3) ? q_b[q_b.size()-3] : 8'h00;
      e_c = (q_c.size() >= 1) ? q_c[q_c.size()-1] : 16'hA5A5;
      chk("model_a", {16'h0, out_a}, {16'h0, e_a});
      chk("model_b", {24'h0, out_b}, {24'h0, e_b});
      chk("model_c", {16'h0, out_c}, {16'h0, e_c});
   end

   task automatic tick();
      #5 clk = 1'b1;
      #5 clk = 1'b0;
   endtask

   initial begin
      // reset with clock idle
      #1 rst = 1'b0;
      #1;
      chk("rst_a", {16'h0, out_a}, 32'h0);
      chk("rst_b", {24'h0, out_b}, 32'h0);
      chk("rst_c", {16'h0, out_c}, 32'h0000A5A5);
      #3 rst = 1'b1;
      #1;
      chk("release_nochange_a", {16'h0, out_a}, 32'h0);
      chk("release_nochange_c", {16'h0, out_c}, 32'h0000A5A5);

      in_a = 16'd1; in_c = 16'd5;
      tick();
      chk("first_edge_a", {16'h0, out_a}, 32'd1);
      chk("first_edge_c", {16'h0, out_c}, 32'd5);

      in_a = 16'd45;
      tick();
      chk("cap45", {16'h0, out_a}, 32'd45);
      in_a = 16'd100;
      #2;
      chk("hold45", {16'h0, out_a}, 32'd45);
      tick();
      chk("cap100", {16'h0, out_a}, 32'd100);

      in_a = 16'd300;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold300", {16'h0, out_a}, 32'd300);
      end
      in_a = 16'hFFFF;
      tick();
      chk("all_ones", {16'h0, out_a}, 32'h0000FFFF);
      chk("msb_bit0", {31'h0, out_a[0]}, 32'd1);

      for (int i = 1; i <= 5; i++) begin
         in_b = 8'(i);
         tick();
         if (i >= 3) chk("lat3", {24'h0, out_b}, 32'(i - 2));
      end

      in_a = 16'h1234;
      tick();
      chk("pre_rst", {16'h0, out_a}, 32'h1234);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_a", {16'h0, out_a}, 32'h0);
      chk("async_rst_b", {24'h0, out_b}, 32'h0);
      chk("async_rst_c", {16'h0, out_c}, 32'h0000A5A5);
      in_a = 16'd7; in_b = 8'd7;
      tick();
      tick();
      chk("clk_ignored", {16'h0, out_a}, 32'h0);
      rst = 1'b1;
      in_b = 8'd9;
      tick();
      in_b = 8'd0;
      chk("flush1", {24'h0, out_b}, 32'h0);
      tick();
      chk("flush2", {24'h0, out_b}, 32'h0);
      tick();
      chk("lat3_after_rst", {24'h0, out_b}, 32'd9);

      for (int i = 0; i < 300; i++) begin
         in_a = 16'($urandom);
         in_b = 8'($urandom);
         in_c = 16'($urandom);
         if ($urandom_range(0, 19) == 0) begin
            #2 rst = 1'b0;
            #1 rst = 1'b1;
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
